// File: rtl/fetch_sequencer.sv
// Fetch controller: PC enables, single-outstanding imem handshake and a one-entry instruction buffer.
// Optional perf counters are built when FETCH_SEQ_PERF_EN is defined.
module fetch_sequencer #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] io_pc,
  output logic            io_stall_en,
  output logic            io_jal_en,
  output logic            io_jalr_en,
  input  logic            io_redirect_jal,
  input  logic            io_redirect_jalr,
  input  logic            io_hazard_stall,
  output logic            io_imem_req_valid,
  output logic [XLEN-1:0] io_imem_req_addr,
  input  logic            io_imem_req_ready,
  input  logic            io_imem_resp_valid,
  input  logic [XLEN-1:0] io_imem_resp_data,
  output logic            io_inst_valid,
  output logic [XLEN-1:0] io_inst_data,
  output logic [XLEN-1:0] io_inst_pc,
  input  logic            io_inst_ready,
`ifdef FETCH_SEQ_PERF_EN
  output logic [15:0]     io_perf_redirects,
  output logic [15:0]     io_perf_drops,
`endif
  output logic            io_timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_HOLD,
    ST_FLUSH
  } state_e;

  localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

  state_e          state_q;
  logic            inst_valid_q;
  logic [XLEN-1:0] inst_data_q;
  logic [XLEN-1:0] inst_pc_q;
  logic [7:0]      tmo_cnt_q;
  logic [7:0]      tmo_cnt_d;
  logic [7:0]      tmo_inc;
  logic            tmo_hit;
  logic            timeout_err_q;
  logic            redirect;
  logic            capture;

  assign redirect = io_redirect_jal | io_redirect_jalr;
  assign capture  = (state_q == ST_RESP) & io_imem_resp_valid & ~redirect;

  assign io_jal_en         = io_redirect_jal;
  assign io_jalr_en        = io_redirect_jalr & ~io_redirect_jal;
  // PC advances only on the edge that latches the fetched word.
  assign io_stall_en       = ~capture;
  assign io_imem_req_valid = (state_q == ST_REQ);
  assign io_imem_req_addr  = io_pc;
  assign io_inst_valid     = inst_valid_q;
  assign io_inst_data      = inst_data_q;
  assign io_inst_pc        = inst_pc_q;
  assign io_timeout_err    = timeout_err_q;

  // Counter saturates so a stuck memory never wraps back below the limit.
  always_comb begin
    tmo_inc   = (tmo_cnt_q == 8'hFF) ? tmo_cnt_q : tmo_cnt_q + 8'd1;
    tmo_hit   = (state_q == ST_RESP) && (tmo_inc == TMO_LIMIT);
    tmo_cnt_d = 8'd0;
    if (state_q == ST_RESP && !io_imem_resp_valid && !redirect) begin
      tmo_cnt_d = tmo_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      inst_valid_q  <= 1'b0;
      inst_data_q   <= '0;
      inst_pc_q     <= '0;
      tmo_cnt_q     <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      if (tmo_hit) begin
        timeout_err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: state_q <= ST_REQ;
        ST_REQ: begin
          // An accepted request during a redirect still owes us a response to discard.
          if (io_imem_req_ready) begin
            state_q <= redirect ? ST_FLUSH : ST_RESP;
          end
        end
        ST_RESP: begin
          if (io_imem_resp_valid) begin
            if (redirect) begin
              state_q <= ST_REQ;
            end else begin
              inst_valid_q <= 1'b1;
              inst_data_q  <= io_imem_resp_data;
              inst_pc_q    <= io_pc;
              state_q      <= ST_HOLD;
            end
          end else if (redirect) begin
            state_q <= ST_FLUSH;
          end
        end
        ST_HOLD: begin
          if (redirect || (io_inst_ready && !io_hazard_stall)) begin
            inst_valid_q <= 1'b0;
            state_q      <= ST_REQ;
          end
        end
        ST_FLUSH: begin
          if (io_imem_resp_valid) begin
            state_q <= ST_REQ;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] perf_redir_q;
  logic [15:0] perf_drop_q;
  logic        drop;

  assign drop = ((state_q == ST_RESP) & io_imem_resp_valid & redirect) |
                ((state_q == ST_FLUSH) & io_imem_resp_valid);

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_redir_q <= 16'd0;
      perf_drop_q  <= 16'd0;
    end else begin
      if (redirect && perf_redir_q != 16'hFFFF) begin
        perf_redir_q <= perf_redir_q + 16'd1;
      end
      if (drop && perf_drop_q != 16'hFFFF) begin
        perf_drop_q <= perf_drop_q + 16'd1;
      end
    end
  end

  assign io_perf_redirects = perf_redir_q;
  assign io_perf_drops     = perf_drop_q;
`endif

endmodule
